// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: prescale codes, size defaults and the mid-bit edge helper shared by the UART RX sampler
package uart_rx_pkg;
  localparam logic [5:0] PRESC_8  = 6'd8;
  localparam logic [5:0] PRESC_16 = 6'd16;
  localparam logic [5:0] PRESC_32 = 6'd32;
  localparam int EDGE_W_DEF   = 6;
  localparam int MAX_BITS_DEF = 11;
  function automatic logic [5:0] mid_edge(input logic [5:0] p);
    return p >> 1;
  endfunction
endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// uart_rx_edge_bit_counter: latched prescale, per-bit oversampling edge counter and saturating bit counter
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int EDGE_W   = EDGE_W_DEF,
  parameter int MAX_BITS = MAX_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        prescale,
  input  logic              enable,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [3:0]        bit_cnt,
  output logic [5:0]        p_lat
);
  logic [5:0] w_p_next;
  logic       w_wrap;
  assign w_p_next = (prescale == PRESC_16 || prescale == PRESC_32) ? prescale : PRESC_8;
  assign w_wrap   = edge_cnt == EDGE_W'(p_lat - 6'd1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      p_lat    <= PRESC_8;
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      p_lat    <= enable ? p_lat : w_p_next;
      edge_cnt <= (!enable || w_wrap) ? '0 : edge_cnt + EDGE_W'(1);
      bit_cnt  <= !enable ? '0 : (w_wrap && bit_cnt != 4'(MAX_BITS)) ? bit_cnt + 4'd1 : bit_cnt;
    end
endmodule

// File: rtl/uart_rx_edge_sampler.sv
// uart_rx_edge_sampler: edge/bit counting plus 3-sample mid-bit majority vote; UART_RX_IN_SYNC_EN adds a 2-flop RX_IN synchronizer exported as rx_sync
module uart_rx_edge_sampler
  import uart_rx_pkg::*;
#(
  parameter int EDGE_W   = EDGE_W_DEF,
  parameter int MAX_BITS = MAX_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RX_IN,
  input  logic [5:0]        prescale,
  input  logic              enable,
  input  logic              data_samp_en,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [3:0]        bit_cnt,
  output logic              sampled_bit,
`ifdef UART_RX_IN_SYNC_EN
  output logic              rx_sync,
`endif
  output logic              samp_valid
);
  logic [5:0] w_p;
  logic [5:0] w_mid;
  logic       w_rx;
  logic       w_at0;
  logic       w_at1;
  logic       w_at2;
  logic       w_commit;
  logic       w_vote;
  logic       r_s0;
  logic       r_s1;
  logic       r_c0;
  logic       r_c1;
`ifdef UART_RX_IN_SYNC_EN
  logic [1:0] r_sync;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], RX_IN};
  assign rx_sync = r_sync[1];
  assign w_rx    = r_sync[1];
`else
  assign w_rx = RX_IN;
`endif
  uart_rx_edge_bit_counter #(.EDGE_W(EDGE_W), .MAX_BITS(MAX_BITS)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .prescale (prescale),
    .enable   (enable),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .p_lat    (w_p)
  );
  assign w_mid    = mid_edge(w_p);
  assign w_at0    = data_samp_en && edge_cnt == EDGE_W'(w_mid - 6'd2);
  assign w_at1    = data_samp_en && edge_cnt == EDGE_W'(w_mid - 6'd1);
  assign w_at2    = data_samp_en && edge_cnt == EDGE_W'(w_mid);
  assign w_commit = w_at2 && r_c1;
  assign w_vote   = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_s0        <= 1'b0;
      r_s1        <= 1'b0;
      r_c0        <= 1'b0;
      r_c1        <= 1'b0;
      sampled_bit <= 1'b1;
      samp_valid  <= 1'b0;
    end else begin
      r_s0        <= w_at0 ? w_rx : r_s0;
      r_s1        <= w_at1 ? w_rx : r_s1;
      r_c0        <= w_at0;
      r_c1        <= w_at1 && r_c0;
      sampled_bit <= w_commit ? w_vote : sampled_bit;
      samp_valid  <= w_commit;
    end
endmodule

// File: tb/tb_uart_rx_edge_sampler.sv
// tb_uart_rx_edge_sampler: scoreboard bench for counting, prescale latch, majority vote and sampling enable
module tb_uart_rx_edge_sampler;
  logic       clk = 1'b0;
  logic       rst;
  logic       RX_IN;
  logic [5:0] prescale;
  logic       enable;
  logic       data_samp_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       samp_valid;
`ifdef UART_RX_IN_SYNC_EN
  logic       rx_sync;
`endif
  int         errors = 0;
  int         checks = 0;
  logic       m_sb;
  logic       exp_q[$];
  logic [2:0] smp_tab[8];
  logic [2:0] en_tab[8];
  logic       lvl_tab[8];

  always #5 clk = ~clk;

  uart_rx_edge_sampler dut (
    .clk          (clk),
    .rst          (rst),
    .RX_IN        (RX_IN),
    .prescale     (prescale),
    .enable       (enable),
    .data_samp_en (data_samp_en),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .sampled_bit  (sampled_bit),
`ifdef UART_RX_IN_SYNC_EN
    .rx_sync      (rx_sync),
`endif
    .samp_valid   (samp_valid)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic maj3(input logic [2:0] v);
    return (int'(v[0]) + int'(v[1]) + int'(v[2])) >= 2;
  endfunction

  task automatic chk_cnt(input string name, input logic [5:0] exp_e, input logic [3:0] exp_b);
    checks++;
    if (edge_cnt !== exp_e) begin
      errors++;
      $display("FAIL %s edge_cnt got=%0d exp=%0d", name, edge_cnt, exp_e);
    end
    checks++;
    if (bit_cnt !== exp_b) begin
      errors++;
      $display("FAIL %s bit_cnt got=%0d exp=%0d", name, bit_cnt, exp_b);
    end
  endtask

  task automatic run_frame(input int p, input int n);
    int         m;
    int         k;
    logic       d;
    logic       eff;
    logic       h1;
    logic       h2;
    logic       pend;
    logic       got;
    logic [2:0] s;
    m = p / 2;
    s = 3'b000;
    prescale = 6'(p);
    enable = 1'b0;
    data_samp_en = 1'b0;
    RX_IN = 1'b1;
    tick;
    tick;
    h1 = 1'b1;
    h2 = 1'b1;
    enable = 1'b1;
    for (int b = 0; b < n; b++)
      for (int e = 0; e < p; e++) begin
        k = e - (m - 2);
        d = (k >= 0 && k <= 2) ? smp_tab[b][k] : lvl_tab[b];
        data_samp_en = (k >= 0 && k <= 2) ? en_tab[b][k] : 1'b1;
        RX_IN = d;
`ifdef UART_RX_IN_SYNC_EN
        eff = h2;
`else
        eff = d;
`endif
        if (k >= 0 && k <= 2) s[k] = eff;
        pend = (k == 2 && en_tab[b] == 3'b111);
        if (pend) begin
          exp_q.push_back(maj3(s));
          m_sb = maj3(s);
        end
        tick;
        h2 = h1;
        h1 = d;
        checks++;
        if (samp_valid !== pend) begin
          errors++;
          $display("FAIL samp_valid p=%0d bit=%0d edge=%0d got=%b exp=%b", p, b, e + 1, samp_valid, pend);
        end
        checks++;
        if (sampled_bit !== m_sb) begin
          errors++;
          $display("FAIL sampled_hold p=%0d bit=%0d edge=%0d got=%b exp=%b", p, b, e + 1, sampled_bit, m_sb);
        end
        if (samp_valid === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra p=%0d bit=%0d got=%b exp=none", p, b, sampled_bit);
          end else begin
            got = exp_q.pop_front();
            if (sampled_bit !== got) begin
              errors++;
              $display("FAIL sb_vote p=%0d bit=%0d got=%b exp=%b", p, b, sampled_bit, got);
            end
          end
        end
      end
    enable = 1'b0;
    data_samp_en = 1'b0;
    tick;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_missing p=%0d got=%0d exp=0", p, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    enable = 1'b0;
    data_samp_en = 1'b0;
    RX_IN = 1'b1;
    prescale = 6'd8;
    m_sb = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    enable = 1'b1;
    data_samp_en = 1'b1;
    RX_IN = 1'b0;
    repeat (4) tick;
    chk_cnt("pre_reset", 6'd4, 4'd0);
    #2 rst = 1'b1;
    #1;
    chk_cnt("async_reset", 6'd0, 4'd0);
    checks++;
    if (sampled_bit !== 1'b1) begin
      errors++;
      $display("FAIL reset_sampled got=%b exp=1", sampled_bit);
    end
    checks++;
    if (samp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got=%b exp=0", samp_valid);
    end
    prescale = 6'd16;
    tick;
    rst = 1'b0;
    data_samp_en = 1'b0;
    tick;
    checks++;
    if (samp_valid !== 1'b0 || sampled_bit !== 1'b1) begin
      errors++;
      $display("FAIL no_pending got=%b%b exp=01", samp_valid, sampled_bit);
    end
    repeat (7) tick;
    chk_cnt("reset_p8", 6'd0, 4'd1);
  endtask

  task automatic test_counting;
    prescale = 6'd8;
    enable = 1'b0;
    data_samp_en = 1'b0;
    tick;
    enable = 1'b1;
    for (int i = 1; i <= 96; i++) begin
      tick;
      chk_cnt("count", 6'(i % 8), 4'((i / 8) > 11 ? 11 : (i / 8)));
    end
  endtask

  task automatic test_majority;
    lvl_tab[0] = 1'b0; smp_tab[0] = 3'b010; en_tab[0] = 3'b111;
    lvl_tab[1] = 1'b1; smp_tab[1] = 3'b111; en_tab[1] = 3'b111;
    lvl_tab[2] = 1'b1; smp_tab[2] = 3'b110; en_tab[2] = 3'b111;
    lvl_tab[3] = 1'b0; smp_tab[3] = 3'b001; en_tab[3] = 3'b111;
    lvl_tab[4] = 1'b1; smp_tab[4] = 3'b101; en_tab[4] = 3'b111;
    run_frame(16, 5);
  endtask

  task automatic test_samp_en;
    lvl_tab[0] = 1'b0; smp_tab[0] = 3'b000; en_tab[0] = 3'b111;
    lvl_tab[1] = 1'b1; smp_tab[1] = 3'b111; en_tab[1] = 3'b000;
    lvl_tab[2] = 1'b1; smp_tab[2] = 3'b111; en_tab[2] = 3'b101;
    lvl_tab[3] = 1'b1; smp_tab[3] = 3'b011; en_tab[3] = 3'b111;
    lvl_tab[4] = 1'b0; smp_tab[4] = 3'b000; en_tab[4] = 3'b011;
    lvl_tab[5] = 1'b0; smp_tab[5] = 3'b100; en_tab[5] = 3'b111;
    run_frame(8, 6);
  endtask

  task automatic test_back_to_back;
    for (int b = 0; b < 8; b++) begin
      lvl_tab[b] = b[0];
      smp_tab[b] = 3'(b * 3 + 1);
      en_tab[b]  = 3'b111;
    end
    run_frame(32, 8);
  endtask

  task automatic test_prescale_change;
    prescale = 6'd8;
    enable = 1'b0;
    tick;
    enable = 1'b1;
    repeat (3) tick;
    prescale = 6'd32;
    repeat (4) tick;
    chk_cnt("frozen_p_last", 6'd7, 4'd0);
    tick;
    chk_cnt("frozen_p_wrap", 6'd0, 4'd1);
    enable = 1'b0;
    tick;
    chk_cnt("enable_clear", 6'd0, 4'd0);
    enable = 1'b1;
    repeat (31) tick;
    chk_cnt("p32_last", 6'd31, 4'd0);
    tick;
    chk_cnt("p32_wrap", 6'd0, 4'd1);
    prescale = 6'd12;
    enable = 1'b0;
    tick;
    enable = 1'b1;
    repeat (7) tick;
    chk_cnt("p12_last", 6'd7, 4'd0);
    tick;
    chk_cnt("p12_wrap", 6'd0, 4'd1);
  endtask

  task automatic test_enable_collision;
    prescale = 6'd8;
    enable = 1'b0;
    tick;
    enable = 1'b1;
    repeat (31) tick;
    chk_cnt("collide_pre", 6'd7, 4'd3);
    enable = 1'b0;
    tick;
    chk_cnt("collide_clear", 6'd0, 4'd0);
  endtask

`ifdef UART_RX_IN_SYNC_EN
  task automatic test_sync;
    RX_IN = 1'b1;
    enable = 1'b0;
    tick;
    tick;
    RX_IN = 1'b0;
    tick;
    checks++;
    if (rx_sync !== 1'b1) begin
      errors++;
      $display("FAIL sync_n1 got=%b exp=1", rx_sync);
    end
    tick;
    checks++;
    if (rx_sync !== 1'b0) begin
      errors++;
      $display("FAIL sync_n2 got=%b exp=0", rx_sync);
    end
    RX_IN = 1'b1;
  endtask
`endif

  initial begin
    test_reset;
    test_counting;
    test_majority;
    test_samp_en;
    test_back_to_back;
    test_prescale_change;
    test_enable_collision;
`ifdef UART_RX_IN_SYNC_EN
    test_sync;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
